// File: rtl/mem_pkg.sv
// Shared types for the BRAM port arbiter: request struct, owner enum and response tag.
// Optional build macro BRAM_ARB_ADDR_CHECK_EN adds out-of-range address detection.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic [31:0]       addr;
        logic [BE_W-1:0]   we;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic   is_read;
        owner_e owner;
        logic   err;
    } rsp_tag_t;

    // Under contention the requester that was not granted last wins.
    function automatic owner_e rr_pick(input owner_e last);
        return (last == OWN_M1) ? OWN_M0 : OWN_M1;
    endfunction

endpackage

// File: rtl/bram_rsp_pipe.sv
// Shift register of response tags that tracks each grant through the BRAM read latency.
// The err bit is only ever set in builds with BRAM_ARB_ADDR_CHECK_EN defined.
module bram_rsp_pipe
    import mem_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_tag_t tag_i,
    output rsp_tag_t tag_o
);

    rsp_tag_t stage_q [Depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between M0 and M1, routing read data back to its issuer.
// Define BRAM_ARB_ADDR_CHECK_EN to reject out-of-range addresses and add the m*_err outputs.
module bram_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [31:0]       m0_addr,
    input  logic [BE_W-1:0]   m0_we,
    input  logic [WORD_W-1:0] m0_wdata,
    output logic              m0_rvalid,
    output logic [WORD_W-1:0] m0_rdata,
`ifdef BRAM_ARB_ADDR_CHECK_EN
    output logic              m0_err,
`endif

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [31:0]       m1_addr,
    input  logic [BE_W-1:0]   m1_we,
    input  logic [WORD_W-1:0] m1_wdata,
    output logic              m1_rvalid,
    output logic [WORD_W-1:0] m1_rdata,
`ifdef BRAM_ARB_ADDR_CHECK_EN
    output logic              m1_err,
`endif

    output logic              bram_en,
    output logic [BE_W-1:0]   bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WORD_W-1:0] bram_din,
    input  logic [WORD_W-1:0] bram_dout,
    output logic              bram_regce,
    output logic              bram_rst
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_port_arbiter: READ_LATENCY must be 1 or 2");
    end

    owner_e   prio_last_q, prio_last_d;
    logic     grant0, grant1, gnt_any;
    owner_e   gnt_owner;
    mem_req_t req0, req1, req_sel;
    logic     addr_err;
    rsp_tag_t tag_in, tag_out;
    logic     hit0, hit1;
    logic [WORD_W-1:0] rsp_data;
    logic [WORD_W-1:0] rdata0_q, rdata1_q;

    assign req0 = '{addr: m0_addr, we: m0_we, wdata: m0_wdata};
    assign req1 = '{addr: m1_addr, we: m1_we, wdata: m1_wdata};

    // Nothing is granted while rst is high, so no request slips into a cleared pipeline.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (m0_valid && m1_valid) begin
                if (rr_pick(prio_last_q) == OWN_M0) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (m0_valid) begin
                grant0 = 1'b1;
            end else if (m1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign gnt_any   = grant0 | grant1;
    assign gnt_owner = grant1 ? OWN_M1 : OWN_M0;
    assign req_sel   = grant1 ? req1 : req0;
    assign m0_ready  = grant0;
    assign m1_ready  = grant1;

`ifdef BRAM_ARB_ADDR_CHECK_EN
    assign addr_err = gnt_any && (req_sel.addr[31:ADDR_W+2] != '0);
`else
    assign addr_err = 1'b0;
`endif

    // Word-address bits of the BRAM are a subset of the byte address; the rest feeds nothing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr, m1_addr};

    assign bram_en    = gnt_any && !addr_err;
    assign bram_we    = bram_en ? req_sel.we : '0;
    assign bram_addr  = req_sel.addr[ADDR_W+1:2];
    assign bram_din   = req_sel.wdata;
    assign bram_regce = 1'b1;
    assign bram_rst   = rst;

    always_comb begin
        prio_last_d = prio_last_q;
        if (gnt_any) begin
            prio_last_d = gnt_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_last_q <= OWN_M1;
        end else begin
            prio_last_q <= prio_last_d;
        end
    end

    assign tag_in = '{is_read: gnt_any && (req_sel.we == '0), owner: gnt_owner, err: addr_err};

    bram_rsp_pipe #(
        .Depth (READ_LATENCY)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign hit0     = !rst && tag_out.is_read && (tag_out.owner == OWN_M0);
    assign hit1     = !rst && tag_out.is_read && (tag_out.owner == OWN_M1);
    assign rsp_data = tag_out.err ? '0 : bram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (hit0) rdata0_q <= rsp_data;
            if (hit1) rdata1_q <= rsp_data;
        end
    end

    // Response data is live in the rvalid cycle and held afterwards for the requester.
    assign m0_rvalid = hit0;
    assign m1_rvalid = hit1;
    assign m0_rdata  = rst ? '0 : (hit0 ? rsp_data : rdata0_q);
    assign m1_rdata  = rst ? '0 : (hit1 ? rsp_data : rdata1_q);

`ifdef BRAM_ARB_ADDR_CHECK_EN
    assign m0_err = hit0 && tag_out.err;
    assign m1_err = hit1 && tag_out.err;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a write-first BRAM model on the data port.
// Define BRAM_ARB_ADDR_CHECK_EN to also exercise the out-of-range address path.
module tb_bram_port_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned RL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_we;
    logic        m1_valid, m1_ready, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_we;
    logic        bram_en, bram_regce, bram_rst;
    logic [3:0]  bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0] bram_din, bram_dout;
`ifdef BRAM_ARB_ADDR_CHECK_EN
    logic        m0_err, m1_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDR_W       (AW),
        .READ_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_valid   (m0_valid),
        .m0_ready   (m0_ready),
        .m0_addr    (m0_addr),
        .m0_we      (m0_we),
        .m0_wdata   (m0_wdata),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
`ifdef BRAM_ARB_ADDR_CHECK_EN
        .m0_err     (m0_err),
`endif
        .m1_valid   (m1_valid),
        .m1_ready   (m1_ready),
        .m1_addr    (m1_addr),
        .m1_we      (m1_we),
        .m1_wdata   (m1_wdata),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
`ifdef BRAM_ARB_ADDR_CHECK_EN
        .m1_err     (m1_err),
`endif
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .bram_regce (bram_regce),
        .bram_rst   (bram_rst)
    );

    // Write-first BRAM model with optional output register.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] dout1 = '0, dout2 = '0, wtmp;
    always @(posedge clk) begin
        if (bram_en) begin
            wtmp = mem[bram_addr];
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) wtmp[b*8 +: 8] = bram_din[b*8 +: 8];
            end
            mem[bram_addr] <= wtmp;
            dout1 <= wtmp;
        end
        if (bram_rst) dout2 <= '0;
        else if (bram_regce) dout2 <= dout1;
    end
    assign bram_dout = (RL == 1) ? dout1 : dout2;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = '0; m0_we = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_we = '0; m1_wdata = '0;
    endtask

    task automatic drive(input bit m, input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] wd);
        if (!m) begin
            m0_valid = 1'b1; m0_addr = a; m0_we = we; m0_wdata = wd;
        end else begin
            m1_valid = 1'b1; m1_addr = a; m1_we = we; m1_wdata = wd;
        end
    endtask

    // Single uncontended request: present at negedge, check grant, return after the grant edge.
    task automatic issue(input bit m, input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] wd, input string nm);
        @(negedge clk);
        idle_inputs();
        drive(m, a, we, wd);
        #1;
        n_checks++;
        if ((m ? m1_ready : m0_ready) !== 1'b1) begin
            n_fail++; $display("FAIL %s ready: got %b want 1", nm, m ? m1_ready : m0_ready);
        end
        n_checks++;
        if (bram_en !== 1'b1 || bram_we !== we || bram_addr !== a[AW+1:2] || bram_din !== wd) begin
            n_fail++;
            $display("FAIL %s bram drive: en=%b we=%h addr=%h din=%h want en=1 we=%h addr=%h din=%h",
                     nm, bram_en, bram_we, bram_addr, bram_din, we, a[AW+1:2], wd);
        end
        @(posedge clk);
    endtask

    task automatic do_write(input bit m, input logic [31:0] a, input logic [3:0] we,
                            input logic [31:0] wd, input string nm);
        issue(m, a, we, wd, nm);
        @(negedge clk);
        idle_inputs();
    endtask

    // Response must appear exactly RL cycles after the grant edge, for the issuer only.
    task automatic wait_rsp(input bit m, input logic [31:0] exp, input string nm);
        for (int k = 1; k <= RL; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
            #1;
            n_checks++;
            if ((m ? m1_rvalid : m0_rvalid) !== (k == RL)) begin
                n_fail++; $display("FAIL %s rvalid at +%0d: got %b want %b", nm, k,
                                   m ? m1_rvalid : m0_rvalid, k == RL);
            end
        end
        n_checks++;
        if ((m ? m0_rvalid : m1_rvalid) !== 1'b0) begin
            n_fail++; $display("FAIL %s other rvalid: got 1 want 0", nm);
        end
        n_checks++;
        if ((m ? m1_rdata : m0_rdata) !== exp) begin
            n_fail++; $display("FAIL %s rdata: got %h want %h", nm, m ? m1_rdata : m0_rdata, exp);
        end
    endtask

    task automatic do_read(input bit m, input logic [31:0] a, input logic [31:0] exp,
                           input string nm);
        issue(m, a, 4'h0, 32'h0, nm);
        wait_rsp(m, exp, nm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || bram_en !== 1'b0 || bram_rst !== 1'b1) begin
            n_fail++; $display("FAIL reset grant: ready=%b%b en=%b brst=%b want 00 0 1",
                               m0_ready, m1_ready, bram_en, bram_rst);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({m0_ready, m1_ready, m0_rvalid, m1_rvalid, bram_en, bram_we, bram_rst} !== '0 ||
                m0_rdata !== '0 || m1_rdata !== '0 || bram_regce !== 1'b1) begin
                n_fail++;
                $display("FAIL idle cycle %0d: rdy=%b%b rv=%b%b en=%b we=%h rd0=%h rd1=%h ce=%b",
                         c, m0_ready, m1_ready, m0_rvalid, m1_rvalid, bram_en, bram_we,
                         m0_rdata, m1_rdata, bram_regce);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_read();
        do_write(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, "wr_m0");
        do_read(1'b0, 32'h10, 32'hDEADBEEF, "rd_m0");
    endtask

    task automatic test_byte_write();
        do_write(1'b1, 32'h20, 4'hF, 32'h11223344, "preload");
        do_write(1'b1, 32'h20, 4'b0010, 32'h0000AA00, "byte_wr");
        do_read(1'b1, 32'h20, 32'h1122AA44, "byte_rd");
    endtask

    task automatic test_back_to_back();
        do_read(1'b0, 32'h20, 32'h1122AA44, "b2b_pre");
        issue(1'b0, 32'h30, 4'hF, 32'hCAFEF00D, "b2b_wr");
        @(negedge clk);
        idle_inputs();
        drive(1'b0, 32'h30, 4'h0, 32'h0);
        #1;
        n_checks++;
        if (m0_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_rd ready: got %b want 1", m0_ready);
        end
        n_checks++;
        if (m0_rdata !== 32'h1122AA44) begin
            n_fail++; $display("FAIL b2b rdata hold: got %h want 1122aa44", m0_rdata);
        end
        @(posedge clk);
        wait_rsp(1'b0, 32'hCAFEF00D, "b2b_rd");
    endtask

    task automatic test_contention();
        logic [31:0] exp [2];
        exp[0] = 32'hA0A0A0A0;
        exp[1] = 32'h5B5B5B5B;
        do_write(1'b1, 32'h0, 4'hF, exp[0], "cont_pre0");
        do_write(1'b1, 32'h4, 4'hF, exp[1], "cont_pre1");
        for (int c = 0; c < 4 + RL; c++) begin
            idle_inputs();
            if (c < 4) begin
                drive(1'b0, 32'h0, 4'h0, 32'h0);
                drive(1'b1, 32'h4, 4'h0, 32'h0);
            end
            #1;
            if (c < 4) begin
                n_checks++;
                if (m0_ready !== (c % 2 == 0) || m1_ready !== (c % 2 == 1)) begin
                    n_fail++; $display("FAIL cont grant %0d: ready=%b%b want m0=%b", c,
                                       m0_ready, m1_ready, c % 2 == 0);
                end
            end
            if (c >= RL) begin
                n_checks++;
                if (m0_rvalid !== ((c - RL) % 2 == 0) || m1_rvalid !== ((c - RL) % 2 == 1)) begin
                    n_fail++; $display("FAIL cont rvalid %0d: rv=%b%b want m0=%b", c,
                                       m0_rvalid, m1_rvalid, (c - RL) % 2 == 0);
                end
                n_checks++;
                if (((c - RL) % 2 == 0 ? m0_rdata : m1_rdata) !== exp[(c - RL) % 2]) begin
                    n_fail++; $display("FAIL cont rdata %0d: got %h want %h", c,
                                       (c - RL) % 2 == 0 ? m0_rdata : m1_rdata, exp[(c - RL) % 2]);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        issue(1'b1, 32'h0, 4'h0, 32'h0, "mid_rd");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        m0_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (m1_rvalid !== 1'b0 || m0_ready !== 1'b0 || m1_rdata !== '0 || bram_en !== 1'b0) begin
                n_fail++; $display("FAIL mid reset %0d: rv1=%b rdy0=%b rd1=%h en=%b", c,
                                   m1_rvalid, m0_ready, m1_rdata, bram_en);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < RL + 2; c++) begin
            #1;
            n_checks++;
            if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL dropped read %0d: rv=%b%b want 00", c, m0_rvalid, m1_rvalid);
            end
            @(negedge clk);
        end
        // Leave prio_last at M0, then confirm reset restores M0-wins-first.
        do_write(1'b0, 32'h40, 4'hF, 32'h1, "prio_pre");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h40, 4'h0, 32'h0);
        drive(1'b1, 32'h40, 4'h0, 32'h0);
        #1;
        n_checks++;
        if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            n_fail++; $display("FAIL prio after reset: ready=%b%b want 10", m0_ready, m1_ready);
        end
        @(negedge clk);
        idle_inputs();
        repeat (RL + 1) @(negedge clk);
    endtask

`ifdef BRAM_ARB_ADDR_CHECK_EN
    task automatic test_addr_check();
        @(negedge clk);
        idle_inputs();
        drive(1'b0, 32'h0001_0000, 4'h0, 32'h0);
        #1;
        n_checks++;
        if (m0_ready !== 1'b1 || bram_en !== 1'b0 || bram_we !== 4'h0) begin
            n_fail++; $display("FAIL oor grant: rdy=%b en=%b we=%h want 1 0 0",
                               m0_ready, bram_en, bram_we);
        end
        @(posedge clk);
        for (int k = 1; k <= RL; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
        end
        #1;
        n_checks++;
        if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0 || m1_err !== 1'b0) begin
            n_fail++; $display("FAIL oor rsp: rv=%b err=%b rd=%h err1=%b want 1 1 0 0",
                               m0_rvalid, m0_err, m0_rdata, m1_err);
        end
        do_read(1'b0, 32'h10, 32'hDEADBEEF, "inrange_rd");
        n_checks++;
        if (m0_err !== 1'b0) begin
            n_fail++; $display("FAIL inrange err: got %b want 0", m0_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_contention();
        test_reset_mid_read();
`ifdef BRAM_ARB_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
